// File: rtl/vfx_stream_pkg.sv
// Shared types and frame geometry for the video stream blocks.
package vfx_stream_pkg;

  localparam int IMAGE_WIDTH  = 320;
  localparam int IMAGE_HEIGHT = 240;
  localparam int FRAME_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int PIXEL_BITS   = 12;
  localparam int ADDR_BITS    = 17;

  typedef logic [PIXEL_BITS-1:0] pixel_t;

  typedef struct packed {
    logic   sop;
    logic   eop;
    pixel_t data;
  } beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO of stream beats; head is presented directly from storage.
module stream_skid_fifo
  import vfx_stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output logic [1:0] count,
  output beat_t      head
);

  beat_t      mem_q [0:1];
  beat_t      mem_d [0:1];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push_ok_s, pop_ok_s;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pop_ok_s  = pop && (count_q != 2'd0);
    push_ok_s = push && ((count_q != 2'd2) || pop_ok_s);

    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_beat;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/frame_stream_source.sv
// Streams one frame from a synchronous-read frame buffer as a ready/valid
// packet with sop/eop, one pixel per cycle when not back-pressured.
module frame_stream_source
  import vfx_stream_pkg::*;
#(
  parameter int IMAGE_WIDTH  = vfx_stream_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = vfx_stream_pkg::IMAGE_HEIGHT,
  parameter int ADDR_BITS    = vfx_stream_pkg::ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  rd_en,
  output logic [ADDR_BITS-1:0]  rd_addr,
  input  logic [PIXEL_BITS-1:0] rd_data,
  input  logic                  ready_in,
  output logic                  valid_out,
  output logic                  startofpacket_out,
  output logic                  endofpacket_out,
  output logic [PIXEL_BITS-1:0] data_out
);

  localparam int                   FRAME     = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FRAME - 1);

  fsm_state_t           state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 inflight_q;
  logic                 issue_sop_q, issue_eop_q;
  logic                 frame_done_q, frame_done_d;
  logic                 rd_en_s, pop_s;
  logic [1:0]           fifo_count_s;
  beat_t                fifo_head_s;
  beat_t                push_beat_s;
  logic [2:0]           occupancy_s, limit_s;

  assign valid_out = (fifo_count_s != 2'd0);
  assign pop_s     = valid_out & ready_in;

  // Reads outstanding after this edge may not exceed the two FIFO slots.
  assign occupancy_s = {1'b0, fifo_count_s} + {2'b00, inflight_q};
  assign limit_s     = 3'd2 + {2'b00, pop_s};

  // Frame sequencing: next state, read issue and completion pulse.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rd_en_s      = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          addr_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (occupancy_s < limit_s) begin
          rd_en_s = 1'b1;
          addr_d  = addr_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
          if (addr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          rd_en_s = 1'b0;
        end
      end
      DRAIN: begin
        if (pop_s && fifo_head_s.eop) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; sop/eop flags travel alongside the read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      inflight_q   <= 1'b0;
      issue_sop_q  <= 1'b0;
      issue_eop_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      inflight_q   <= rd_en_s;
      issue_sop_q  <= rd_en_s && (addr_q == '0);
      issue_eop_q  <= rd_en_s && (addr_q == LAST_ADDR);
      frame_done_q <= frame_done_d;
    end
  end

  assign push_beat_s = '{sop: issue_sop_q, eop: issue_eop_q, data: rd_data};

  stream_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_beat (push_beat_s),
    .pop       (pop_s),
    .count     (fifo_count_s),
    .head      (fifo_head_s)
  );

  assign busy              = (state_q != IDLE);
  assign frame_done        = frame_done_q;
  assign rd_en             = rd_en_s;
  assign rd_addr           = addr_q;
  assign startofpacket_out = valid_out & fifo_head_s.sop;
  assign endofpacket_out   = valid_out & fifo_head_s.eop;
  assign data_out          = fifo_head_s.data;

endmodule

// File: tb/tb_frame_stream_source.sv
// Scoreboard bench for frame_stream_source on a reduced 64x24 frame.
module tb_frame_stream_source;

  localparam int W     = 64;
  localparam int H     = 24;
  localparam int FRAME = W * H;

  typedef struct {
    bit          sop;
    bit          eop;
    logic [11:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, frame_done, rd_en;
  logic [16:0] rd_addr;
  logic [11:0] rd_data = 12'h000;
  logic        ready_in = 1'b0;
  logic        valid_out, startofpacket_out, endofpacket_out;
  logic [11:0] data_out;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   exp_rd_addr = 0;
  int   fd_count = 0;
  int   frame_beats = 0;
  bit   rr_stop = 1'b0;

  frame_stream_source #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .busy              (busy),
    .frame_done        (frame_done),
    .rd_en             (rd_en),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .ready_in          (ready_in),
    .valid_out         (valid_out),
    .startofpacket_out (startofpacket_out),
    .endofpacket_out   (endofpacket_out),
    .data_out          (data_out)
  );

  always #5 clk = ~clk;

  // Frame buffer: pixel = addr[11:0], garbage when not read.
  always @(posedge clk) begin
    if (rd_en) rd_data <= rd_addr[11:0];
    else       rd_data <= 12'($urandom);
  end

  // Monitor: scoreboard pops, stability, frame_done timing, read order.
  initial begin
    bit          hold_prev = 1'b0;
    bit          eop_prev = 1'b0;
    logic [13:0] hold_payload = '0;
    int          issued = 0;
    int          xfer = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_prev = 1'b0; eop_prev = 1'b0; issued = 0; xfer = 0;
      end else begin
        checks++;
        if (frame_done !== eop_prev) begin
          errors++;
          $display("FAIL frame_done_timing: got %0b expected %0b", frame_done, eop_prev);
        end
        if (frame_done) fd_count++;
        if (hold_prev) begin
          checks++;
          if (valid_out !== 1'b1 || {startofpacket_out, endofpacket_out, data_out} !== hold_payload) begin
            errors++;
            $display("FAIL payload_stable: got v=%0b %h expected v=1 %h", valid_out,
                     {startofpacket_out, endofpacket_out, data_out}, hold_payload);
          end
        end
        if (rd_en) begin
          checks++;
          if (rd_addr !== 17'(exp_rd_addr) || exp_rd_addr >= FRAME) begin
            errors++;
            $display("FAIL rd_addr: got %0d expected %0d (limit %0d)", rd_addr, exp_rd_addr, FRAME - 1);
          end
          exp_rd_addr++;
          issued++;
        end
        eop_prev = 1'b0;
        if (valid_out && ready_in) begin
          xfer++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL extra_beat: got data %h expected no beat", data_out);
          end else begin
            e = sb.pop_front();
            if ({startofpacket_out, endofpacket_out, data_out} !== {e.sop, e.eop, e.data}) begin
              errors++;
              $display("FAIL beat: got sop=%0b eop=%0b data=%h expected sop=%0b eop=%0b data=%h",
                       startofpacket_out, endofpacket_out, data_out, e.sop, e.eop, e.data);
            end
          end
          frame_beats = startofpacket_out ? 1 : frame_beats + 1;
          eop_prev    = endofpacket_out;
        end
        checks++;
        if (issued - xfer > 2) begin
          errors++;
          $display("FAIL outstanding: got %0d expected <= 2", issued - xfer);
        end
        hold_prev    = valid_out && !ready_in;
        hold_payload = {startofpacket_out, endofpacket_out, data_out};
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic push_frame();
    for (int a = 0; a < FRAME; a++) begin
      sb.push_back('{sop: (a == 0), eop: (a == FRAME - 1), data: 12'(a)});
    end
  endtask

  task automatic pulse_start(input bit accepted);
    @(posedge clk); #1;
    start = 1'b1;
    if (accepted) begin
      push_frame();
      exp_rd_addr = 0;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_frame_done(input int budget, input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (frame_done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done: got no frame_done expected within %0d cycles", name, budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_first_beat(input string name);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (c < 3 && valid_out !== 1'b0) begin
        errors++;
        $display("FAIL %s_latency: got valid=1 in cycle %0d expected 0", name, c);
      end else if (c == 3 && (valid_out !== 1'b1 || startofpacket_out !== 1'b1 || data_out !== 12'h000)) begin
        errors++;
        $display("FAIL %s_first: got v=%0b sop=%0b data=%h expected v=1 sop=1 data=000",
                 name, valid_out, startofpacket_out, data_out);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, frame_done, rd_en, valid_out, startofpacket_out, endofpacket_out, rd_addr, data_out} !== '0) begin
      errors++;
      $display("FAIL reset_values: got busy=%0b fd=%0b rd_en=%0b v=%0b addr=%0d data=%h expected all 0",
               busy, frame_done, rd_en, valid_out, rd_addr, data_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, rd_en, valid_out} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%0b rd_en=%0b v=%0b expected 0", busy, rd_en, valid_out);
    end
  endtask

  task automatic test_full_frame();
    int fd0 = fd_count;
    int gaps = 0;
    ready_in = 1'b1;
    pulse_start(1'b1);
    check_first_beat("full");
    for (int i = 1; i < FRAME; i++) begin
      @(negedge clk);
      if (!valid_out) gaps++;
    end
    checks++;
    if (gaps != 0 || endofpacket_out !== 1'b1) begin
      errors++;
      $display("FAIL full_throughput: got gaps=%0d eop=%0b expected gaps=0 eop=1", gaps, endofpacket_out);
    end
    wait_frame_done(4, "full");
    checks++;
    if (fd_count - fd0 != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL full_count: got done=%0d left=%0d expected done=1 left=0", fd_count - fd0, sb.size());
    end
  endtask

  task automatic test_random_ready();
    int fd0 = fd_count;
    rr_stop = 1'b0;
    fork
      while (!rr_stop) begin
        @(posedge clk); #1;
        ready_in = 1'($urandom_range(0, 1));
      end
    join_none
    pulse_start(1'b1);
    wait_frame_done(FRAME * 8, "random");
    rr_stop = 1'b1;
    @(posedge clk); #2;
    ready_in = 1'b1;
    checks++;
    if (fd_count - fd0 != 1 || sb.size() != 0 || frame_beats != FRAME) begin
      errors++;
      $display("FAIL random_count: got done=%0d left=%0d beats=%0d expected 1 0 %0d",
               fd_count - fd0, sb.size(), frame_beats, FRAME);
    end
  endtask

  task automatic test_backpressure_hold();
    int  n = 0;
    bit  found = 1'b0;
    ready_in = 1'b1;
    pulse_start(1'b1);
    while (!found && n < 400) begin
      @(negedge clk);
      n++;
      if (valid_out && data_out == 12'h063) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL hold_find: got no beat 063 expected within 400 cycles");
    end
    @(posedge clk); #1;
    ready_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b1 || data_out !== 12'h064 || rd_en !== 1'b0) begin
        errors++;
        $display("FAIL hold_stall: got v=%0b data=%h rd_en=%0b expected v=1 data=064 rd_en=0",
                 valid_out, data_out, rd_en);
      end
    end
    @(posedge clk); #1;
    ready_in = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 12'h064) begin
      errors++;
      $display("FAIL hold_resume0: got v=%0b data=%h expected v=1 data=064", valid_out, data_out);
    end
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 12'h065) begin
      errors++;
      $display("FAIL hold_resume1: got v=%0b data=%h expected v=1 data=065", valid_out, data_out);
    end
    wait_frame_done(FRAME + 10, "hold");
  endtask

  task automatic test_start_ignored();
    int fd0 = fd_count;
    int n = 0;
    ready_in = 1'b1;
    pulse_start(1'b1);
    while (!(frame_beats == 500 && busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    pulse_start(1'b0);
    wait_frame_done(FRAME + 10, "ignore");
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL ignore_idle: got v=%0b busy=%0b expected 0 0", valid_out, busy);
      end
    end
    checks++;
    if (fd_count - fd0 != 1 || frame_beats != FRAME || sb.size() != 0) begin
      errors++;
      $display("FAIL ignore_count: got done=%0d beats=%0d left=%0d expected 1 %0d 0",
               fd_count - fd0, frame_beats, sb.size(), FRAME);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    ready_in = 1'b1;
    pulse_start(1'b1);
    while (frame_beats != 1000 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({busy, frame_done, rd_en, valid_out, startofpacket_out, endofpacket_out, rd_addr, data_out} !== '0) begin
        errors++;
        $display("FAIL midreset_values: got busy=%0b v=%0b rd_en=%0b addr=%0d data=%h expected all 0",
                 busy, valid_out, rd_en, rd_addr, data_out);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulse_start(1'b1);
    check_first_beat("restart");
    wait_frame_done(FRAME + 10, "restart");
    checks++;
    if (sb.size() != 0 || frame_beats != FRAME) begin
      errors++;
      $display("FAIL restart_count: got left=%0d beats=%0d expected 0 %0d", sb.size(), frame_beats, FRAME);
    end
  endtask

  task automatic test_back_to_back();
    int fd0 = fd_count;
    int n = 0;
    ready_in = 1'b1;
    pulse_start(1'b1);
    while (!(valid_out && ready_in && endofpacket_out) && n < FRAME + 10) begin
      @(negedge clk);
      n++;
    end
    pulse_start(1'b1);
    check_first_beat("b2b");
    wait_frame_done(FRAME + 10, "b2b");
    checks++;
    if (fd_count - fd0 != 2 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got done=%0d left=%0d expected 2 0", fd_count - fd0, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_random_ready();
    test_backpressure_hold();
    test_start_ignored();
    test_reset_mid_frame();
    test_back_to_back();
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
